// File: rtl/reg_file_cmd_controller.sv
// Serial command decoder: turns UART byte frames (0xAA addr data / 0xBB addr)
// into register-file write/read strobes and returns read data to the UART transmitter.
module reg_file_cmd_controller #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int TIMEOUT_CYCLES      = 8,
    localparam int ADDR_WIDTH         = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_data_valid,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic                  error
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'hBB);
    // Last count value before the increment that would reach TIMEOUT_CYCLES-1,
    // so the error pulse lands TIMEOUT_CYCLES cycles after read_enable.
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_ADDR   = 3'd1,
        WR_DATA   = 3'd2,
        WRITE     = 3'd3,
        RD_ADDR   = 3'd4,
        READ      = 3'd5,
        WAIT_DATA = 3'd6,
        SEND      = 3'd7
    } state_t;

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   cnt_r;

    // Frame decoder FSM; all strobes default low so each pulse lasts one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            address       <= '0;
            write_data    <= '0;
            tx_data       <= '0;
            write_enable  <= 1'b0;
            read_enable   <= 1'b0;
            tx_data_valid <= 1'b0;
            error         <= 1'b0;
        end else begin
            write_enable  <= 1'b0;
            read_enable   <= 1'b0;
            tx_data_valid <= 1'b0;
            error         <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_data_valid) begin
                        if (rx_data == CMD_WRITE) begin
                            state_r <= WR_ADDR;
                        end else if (rx_data == CMD_READ) begin
                            state_r <= RD_ADDR;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (rx_data_valid) begin
                        address <= rx_data[ADDR_WIDTH-1:0];
                        state_r <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_data_valid) begin
                        write_data   <= rx_data;
                        write_enable <= 1'b1;
                        state_r      <= WRITE;
                    end
                end
                WRITE: begin
                    state_r <= IDLE;
                end
                RD_ADDR: begin
                    if (rx_data_valid) begin
                        address     <= rx_data[ADDR_WIDTH-1:0];
                        read_enable <= 1'b1;
                        state_r     <= READ;
                    end
                end
                READ: begin
                    cnt_r   <= '0;
                    state_r <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (read_data_valid) begin
                        tx_data <= read_data;
                        state_r <= SEND;
                    end else if (cnt_r == CNT_LAST) begin
                        error   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data_valid <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_cmd_controller.sv
// Self-checking bench: table of frames plus hand sequences, with a scoreboard of
// expected output events compared by a monitor as the DUT produces them.
module tb_reg_file_cmd_controller;

    localparam int TO = 8;
    localparam int EV_WR = 0, EV_RD = 1, EV_TX = 2, EV_ERR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic [7:0] read_data = 8'h00;
    logic       read_data_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [3:0] address;
    logic       write_enable, read_enable, tx_data_valid, error;
    logic [7:0] write_data, tx_data;

    reg_file_cmd_controller #(.DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .read_data(read_data), .read_data_valid(read_data_valid), .tx_busy(tx_busy),
        .address(address), .write_enable(write_enable), .read_enable(read_enable),
        .write_data(write_data), .tx_data(tx_data), .tx_data_valid(tx_data_valid), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        bit         is_read;
        logic [7:0] addr;
        logic [7:0] data;
        int         rf_delay;
        int         busy;
        int         gap;
        bit         junk;
    } vec_t;

    ev_t        sb[$];
    logic [7:0] exp_mem [16];
    logic [7:0] rf_mem  [16];
    int         errors = 0;
    int         checks = 0;
    int         rf_delay = 1;
    int         rf_busy = 0;
    bit         rf_off = 1'b0;
    bit         prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_event(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required no event", kind, addr, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic push(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // Called at a negedge; strobe is sampled at the next posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_waiting: got %0d pending events, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: strobe exclusivity plus scoreboard comparison.
    initial begin
        forever begin
            int ns;
            @(negedge clk);
            if (reset) begin
                ns = int'(write_enable) + int'(read_enable) + int'(tx_data_valid);
                if (ns != 0) begin
                    checks++;
                    if (ns > 1 || prev_strobe) begin
                        errors++;
                        $display("FAIL strobe_excl: got we=%b re=%b tv=%b prev=%b, required single isolated strobe",
                                 write_enable, read_enable, tx_data_valid, prev_strobe);
                    end
                end
                prev_strobe = (ns != 0);
                if (write_enable) begin
                    rf_mem[address] = write_data;
                    check_event(EV_WR, address, write_data);
                end
                if (read_enable) check_event(EV_RD, address, 8'h00);
                if (tx_data_valid) check_event(EV_TX, 4'h0, tx_data);
                if (error) check_event(EV_ERR, 4'h0, 8'h00);
            end else begin
                prev_strobe = 1'b0;
            end
        end
    end

    // Register-file and transmitter model for table-driven reads.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && read_enable && !rf_off) begin
                repeat (rf_delay) @(negedge clk);
                read_data = rf_mem[address];
                read_data_valid = 1'b1;
                @(negedge clk);
                read_data_valid = 1'b0;
                repeat (rf_busy) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        vec_t vecs [8];
        int   n;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 8'h00;
            rf_mem[i] = 8'h00;
        end
        vecs[0] = '{1'b0, 8'h03, 8'h5A, 1, 0, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h3E, 8'hC3, 1, 0, 3, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 8'h00, 1, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 8'hFE, 8'h00, 3, 2, 2, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 6, 0, 0, 1'b0};
        vecs[6] = '{1'b1, 8'h07, 8'h00, 1, 1, 0, 1'b0};
        vecs[7] = '{1'b1, 8'h0E, 8'h00, 7, 3, 1, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_address", 32'(address), 32'h0);
        check("rst_strobes", {29'h0, write_enable, read_enable, tx_data_valid}, 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Write frame timing: write_enable one cycle after the data strobe.
        push(EV_WR, 4'hE, 8'hF4);
        exp_mem[14] = 8'hF4;
        send_byte(8'hAA);
        send_byte(8'h0E);
        send_byte(8'hF4);
        check("wr_pulse", 32'(write_enable), 32'h1);
        check("wr_addr", 32'(address), 32'hE);
        @(negedge clk);
        check("wr_pulse_end", 32'(write_enable), 32'h0);
        wait_idle();

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            rf_delay = vecs[i].rf_delay;
            rf_busy = vecs[i].busy;
            tx_busy = (vecs[i].busy > 0);
            if (vecs[i].is_read) begin
                push(EV_RD, vecs[i].addr[3:0], 8'h00);
                push(EV_TX, 4'h0, exp_mem[vecs[i].addr[3:0]]);
                send_byte(8'hBB);
                repeat (vecs[i].gap) @(negedge clk);
                send_byte(vecs[i].addr);
            end else begin
                push(EV_WR, vecs[i].addr[3:0], vecs[i].data);
                exp_mem[vecs[i].addr[3:0]] = vecs[i].data;
                send_byte(8'hAA);
                repeat (vecs[i].gap) @(negedge clk);
                send_byte(vecs[i].addr);
                repeat (vecs[i].gap) @(negedge clk);
                send_byte(vecs[i].data);
            end
            if (vecs[i].junk) send_byte(8'h55);
            wait_idle();
        end

        // Read with transmitter busy: tx_data_valid only after busy falls.
        rf_off = 1'b1;
        tx_busy = 1'b1;
        push(EV_RD, 4'h3, 8'h00);
        push(EV_TX, 4'h0, exp_mem[3]);
        send_byte(8'hBB);
        send_byte(8'h03);
        @(negedge clk);
        read_data = rf_mem[3];
        read_data_valid = 1'b1;
        @(negedge clk);
        read_data_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_data_valid) n++;
            @(negedge clk);
        end
        check("busy_no_tv", 32'(n), 32'h0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_tv_after_fall", 32'(tx_data_valid), 32'h1);
        check("busy_tx_data", 32'(tx_data), 32'(exp_mem[3]));
        @(negedge clk);
        check("busy_tv_end", 32'(tx_data_valid), 32'h0);
        wait_idle();

        // Unknown command then a normal write.
        push(EV_ERR, 4'h0, 8'h00);
        push(EV_WR, 4'h1, 8'h12);
        exp_mem[1] = 8'h12;
        send_byte(8'h55);
        check("bad_cmd_err", 32'(error), 32'h1);
        @(negedge clk);
        check("bad_cmd_err_end", 32'(error), 32'h0);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h12);
        wait_idle();

        // Read timeout: error TO cycles after read_enable.
        push(EV_RD, 4'h9, 8'h00);
        push(EV_ERR, 4'h0, 8'h00);
        send_byte(8'hBB);
        send_byte(8'h09);
        check("to_read_en", 32'(read_enable), 32'h1);
        n = 0;
        while (!error && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), 32'(TO));
        check("to_tx_data_kept", 32'(tx_data), 32'(exp_mem[3]));
        wait_idle();
        rf_off = 1'b0;

        // Asynchronous reset mid-frame.
        send_byte(8'hAA);
        send_byte(8'h05);
        #2;
        reset = 1'b0;
        #1;
        check("async_address", 32'(address), 32'h0);
        check("async_write_data", 32'(write_data), 32'h0);
        check("async_tx_data", 32'(tx_data), 32'h0);
        check("async_strobes", {28'h0, write_enable, read_enable, tx_data_valid, error}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push(EV_ERR, 4'h0, 8'h00);
        push(EV_ERR, 4'h0, 8'h00);
        send_byte(8'h05);
        send_byte(8'h77);
        wait_idle();
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
